// File: rtl/word_assembly_arb.sv
// word_assembly_arb: two-channel header-arbitrated byte-to-word assembler with 0xBEEF trailer check.
// Optional WORD_ASSEMBLY_ERR_CNT_EN adds a saturating drop_cnt output.
module word_assembly_arb #(
    parameter int TIMEOUT = 16
) (
    input  logic        div_8_clk,
    input  logic        rst,
    input  logic [7:0]  ch0_data,
    input  logic        ch0_valid,
    output logic        ch0_ready,
    input  logic [7:0]  ch1_data,
    input  logic        ch1_valid,
    output logic        ch1_ready,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        word_src,
    output logic        busy
`ifdef WORD_ASSEMBLY_ERR_CNT_EN
    ,
    output logic [7:0]  drop_cnt
`endif
);
    typedef enum logic {IDLE, COLLECT} state_t;
    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        grant_q, grant_d, last_q, last_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] asm_q, asm_d;
    logic [7:0]  idle_q, idle_d;
    logic [31:0] word_q, word_d;
    logic        wvalid_q, wvalid_d, src_q, src_d;
    logic        h0, h1, tie, win, sel_v, last, rdy, acc, load, drop;
    logic [7:0]  sel_d;
    logic [31:0] full;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        idle_d  = idle_q;
        load    = 1'b0;
        drop    = 1'b0;
        h0      = ch0_valid && ch0_data[7:4] == 4'hA;
        h1      = ch1_valid && ch1_data[7:4] == 4'hA;
        tie     = h0 && h1;
        win     = tie ? ~last_q : h1;
        sel_v   = grant_q ? ch1_valid : ch0_valid;
        sel_d   = grant_q ? ch1_data : ch0_data;
        last    = cnt_q == 2'd3;
        rdy     = !last || !wvalid_q || word_ready;
        acc     = sel_v && rdy;
        full    = {asm_q, sel_d};
        ch0_ready = 1'b1;
        ch1_ready = 1'b1;
        if (state_q == IDLE) begin
            // Tie loser is held off so its header survives to the next frame.
            ch0_ready = !(tie && win);
            ch1_ready = !(tie && !win);
            if (h0 || h1) begin
                state_d = COLLECT;
                grant_d = win;
                last_d  = win;
                asm_d   = {16'h0, win ? ch1_data : ch0_data};
                cnt_d   = 2'd1;
                idle_d  = 8'd0;
            end
        end else begin
            ch0_ready = !grant_q && rdy;
            ch1_ready = grant_q && rdy;
            if (acc) begin
                idle_d = 8'd0;
                asm_d  = full[23:0];
                cnt_d  = cnt_q + 2'd1;
                if (last) begin
                    state_d = IDLE;
                    load    = full[15:0] == 16'hBEEF;
                    drop    = !load;
                end
            end else if (rdy) begin
                // Output-full stalls do not count toward the idle timeout.
                idle_d = idle_q + 8'd1;
                if (idle_d == TO) begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                    idle_d  = 8'd0;
                    drop    = 1'b1;
                end
            end
        end
        wvalid_d = load || (wvalid_q && !word_ready);
        word_d   = load ? full : word_q;
        src_d    = load ? grant_q : src_q;
    end

    always_ff @(posedge div_8_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= 2'd0;
            asm_q    <= 24'h0;
            idle_q   <= 8'd0;
            word_q   <= 32'h0;
            wvalid_q <= 1'b0;
            src_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            idle_q   <= idle_d;
            word_q   <= word_d;
            wvalid_q <= wvalid_d;
            src_q    <= src_d;
        end
    end

`ifdef WORD_ASSEMBLY_ERR_CNT_EN
    logic [7:0] drop_q;
    always_ff @(posedge div_8_clk) begin
        if (rst) drop_q <= 8'd0;
        else if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
    assign drop_cnt = drop_q;
`endif

    assign word_out   = word_q;
    assign word_valid = wvalid_q;
    assign word_src   = src_q;
    assign busy       = state_q == COLLECT;
endmodule

// File: tb/tb_word_assembly_arb.sv
// tb_word_assembly_arb: table-driven directed check of word_assembly_arb with TIMEOUT=4.
module tb_word_assembly_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  d0 = 8'h0, d1 = 8'h0;
    logic        v0 = 1'b0, v1 = 1'b0, wr = 1'b1;
    logic        r0, r1, wv, ws, bz;
    logic [31:0] wo;
`ifdef WORD_ASSEMBLY_ERR_CNT_EN
    logic [7:0]  dc;
`endif
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    word_assembly_arb #(.TIMEOUT(4)) dut (
        .div_8_clk(clk), .rst(rst),
        .ch0_data(d0), .ch0_valid(v0), .ch0_ready(r0),
        .ch1_data(d1), .ch1_valid(v1), .ch1_ready(r1),
        .word_out(wo), .word_valid(wv), .word_ready(wr),
        .word_src(ws), .busy(bz)
`ifdef WORD_ASSEMBLY_ERR_CNT_EN
        , .drop_cnt(dc)
`endif
    );

    typedef struct {
        logic rst; logic [7:0] d0; logic v0; logic [7:0] d1; logic v1; logic wr;
        logic cr; logic r0; logic r1;
        logic cg; logic wv; logic [31:0] wo; logic ws; logic bz; logic [7:0] dc;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic rs, input logic [7:0] a, input logic av,
                                input logic [7:0] b, input logic bv, input logic w,
                                input logic cr, input logic e0, input logic e1,
                                input logic cg, input logic ev, input logic [31:0] eo,
                                input logic es, input logic eb, input logic [7:0] ed);
        vec_t v;
        v = '{rs, a, av, b, bv, w, cr, e0, e1, cg, ev, eo, es, eb, ed};
        tbl.push_back(v);
    endfunction

    task automatic chk(input string n, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", n, row, act, exp);
        end
    endtask

    initial begin
        //   rst d0    v0 d1    v1 wr  cr r0 r1  cg wv wo            ws bz dc
        add(1, 8'h00, 0, 8'h00, 0, 1,  0, 0, 0,  0, 0, 32'h0,        0, 0, 0); // 0
        add(1, 8'h00, 0, 8'h00, 0, 1,  0, 0, 0,  1, 0, 32'h0,        0, 0, 0); // 1 reset state
        add(0, 8'hA0, 1, 8'hA0, 1, 1,  1, 1, 0,  1, 0, 32'h0,        0, 0, 0); // 2 tie -> ch0
        add(0, 8'h11, 1, 8'hA0, 1, 1,  1, 1, 0,  1, 0, 32'h0,        0, 1, 0);
        add(0, 8'hBE, 1, 8'hA0, 1, 1,  1, 1, 0,  1, 0, 32'h0,        0, 1, 0);
        add(0, 8'hEF, 1, 8'hA0, 1, 1,  1, 1, 0,  1, 0, 32'h0,        0, 1, 0);
        add(0, 8'hA0, 1, 8'hA0, 1, 1,  1, 0, 1,  1, 1, 32'hA011BEEF, 0, 0, 0); // 6 tie -> ch1
        add(0, 8'hA0, 1, 8'h12, 1, 1,  1, 0, 1,  1, 0, 32'hA011BEEF, 0, 1, 0);
        add(0, 8'hA0, 1, 8'hBE, 1, 1,  1, 0, 1,  1, 0, 32'hA011BEEF, 0, 1, 0);
        add(0, 8'hA0, 1, 8'hEF, 1, 1,  1, 0, 1,  1, 0, 32'hA011BEEF, 0, 1, 0);
        add(0, 8'h00, 0, 8'h00, 0, 1,  1, 1, 1,  1, 1, 32'hA012BEEF, 1, 0, 0); // 10
        add(0, 8'hA1, 1, 8'h00, 0, 1,  1, 1, 1,  1, 0, 32'hA012BEEF, 1, 0, 0); // 11 ch0 frame
        add(0, 8'h22, 1, 8'h00, 0, 1,  1, 1, 0,  1, 0, 32'hA012BEEF, 1, 1, 0);
        add(0, 8'hBE, 1, 8'h00, 0, 1,  1, 1, 0,  1, 0, 32'hA012BEEF, 1, 1, 0);
        add(0, 8'hEF, 1, 8'h00, 0, 1,  1, 1, 0,  1, 0, 32'hA012BEEF, 1, 1, 0);
        add(0, 8'h00, 0, 8'h00, 0, 1,  1, 1, 1,  1, 1, 32'hA122BEEF, 0, 0, 0); // 15
        add(0, 8'h00, 0, 8'hA5, 1, 1,  1, 1, 1,  1, 0, 32'hA122BEEF, 0, 0, 0); // 16 bad trailer
        add(0, 8'h00, 0, 8'h00, 1, 1,  1, 0, 1,  1, 0, 32'hA122BEEF, 0, 1, 0);
        add(0, 8'h00, 0, 8'h12, 1, 1,  1, 0, 1,  1, 0, 32'hA122BEEF, 0, 1, 0);
        add(0, 8'h00, 0, 8'h34, 1, 1,  1, 0, 1,  1, 0, 32'hA122BEEF, 0, 1, 0);
        add(0, 8'h55, 1, 8'h00, 0, 1,  1, 1, 1,  1, 0, 32'hA122BEEF, 0, 0, 1); // 20 discard
        add(0, 8'h00, 0, 8'h00, 0, 1,  1, 1, 1,  1, 0, 32'hA122BEEF, 0, 0, 1);
        add(0, 8'hA0, 1, 8'h00, 0, 1,  1, 1, 1,  1, 0, 32'hA122BEEF, 0, 0, 1); // 22 timeout
        add(0, 8'h11, 1, 8'h00, 0, 1,  1, 1, 0,  1, 0, 32'hA122BEEF, 0, 1, 1);
        add(0, 8'h00, 0, 8'h00, 0, 1,  1, 1, 0,  1, 0, 32'hA122BEEF, 0, 1, 1);
        add(0, 8'h00, 0, 8'h00, 0, 1,  1, 1, 0,  1, 0, 32'hA122BEEF, 0, 1, 1);
        add(0, 8'h00, 0, 8'h00, 0, 1,  1, 1, 0,  1, 0, 32'hA122BEEF, 0, 1, 1);
        add(0, 8'h00, 0, 8'h00, 0, 1,  1, 1, 0,  1, 0, 32'hA122BEEF, 0, 1, 1);
        add(0, 8'h00, 0, 8'h00, 0, 1,  1, 1, 1,  1, 0, 32'hA122BEEF, 0, 0, 2); // 28
        add(0, 8'hA0, 1, 8'h00, 0, 0,  1, 1, 1,  1, 0, 32'hA122BEEF, 0, 0, 2); // 29 backpressure
        add(0, 8'hFF, 1, 8'h00, 0, 0,  1, 1, 0,  1, 0, 32'hA122BEEF, 0, 1, 2);
        add(0, 8'hBE, 1, 8'h00, 0, 0,  1, 1, 0,  1, 0, 32'hA122BEEF, 0, 1, 2);
        add(0, 8'hEF, 1, 8'h00, 0, 0,  1, 1, 0,  1, 0, 32'hA122BEEF, 0, 1, 2);
        add(0, 8'h00, 0, 8'h00, 0, 0,  1, 1, 1,  1, 1, 32'hA0FFBEEF, 0, 0, 2);
        add(0, 8'hA3, 1, 8'h00, 0, 0,  1, 1, 1,  1, 1, 32'hA0FFBEEF, 0, 0, 2);
        add(0, 8'h44, 1, 8'h00, 0, 0,  1, 1, 0,  1, 1, 32'hA0FFBEEF, 0, 1, 2);
        add(0, 8'hBE, 1, 8'h00, 0, 0,  1, 1, 0,  1, 1, 32'hA0FFBEEF, 0, 1, 2);
        add(0, 8'hEF, 1, 8'h00, 0, 0,  1, 0, 0,  1, 1, 32'hA0FFBEEF, 0, 1, 2); // 37 stall
        add(0, 8'hEF, 1, 8'h00, 0, 0,  1, 0, 0,  1, 1, 32'hA0FFBEEF, 0, 1, 2);
        add(0, 8'hEF, 1, 8'h00, 0, 0,  1, 0, 0,  1, 1, 32'hA0FFBEEF, 0, 1, 2);
        add(0, 8'hEF, 1, 8'h00, 0, 0,  1, 0, 0,  1, 1, 32'hA0FFBEEF, 0, 1, 2);
        add(0, 8'hEF, 1, 8'h00, 0, 0,  1, 0, 0,  1, 1, 32'hA0FFBEEF, 0, 1, 2);
        add(0, 8'hEF, 1, 8'h00, 0, 1,  1, 1, 0,  1, 1, 32'hA0FFBEEF, 0, 1, 2); // 42 pop+load
        add(0, 8'h00, 0, 8'h00, 0, 0,  1, 1, 1,  1, 1, 32'hA344BEEF, 0, 0, 2);
        add(0, 8'h00, 0, 8'h00, 0, 1,  1, 1, 1,  1, 1, 32'hA344BEEF, 0, 0, 2);
        add(0, 8'h00, 0, 8'h00, 0, 1,  1, 1, 1,  1, 0, 32'hA344BEEF, 0, 0, 2);
        add(0, 8'hA7, 1, 8'h00, 0, 1,  1, 1, 1,  1, 0, 32'hA344BEEF, 0, 0, 2); // 46 reset mid-frame
        add(0, 8'h01, 1, 8'h00, 0, 1,  1, 1, 0,  1, 0, 32'hA344BEEF, 0, 1, 2);
        add(1, 8'hBE, 1, 8'h00, 0, 1,  0, 0, 0,  1, 0, 32'hA344BEEF, 0, 1, 2);
        add(0, 8'h00, 0, 8'h00, 0, 1,  1, 1, 1,  1, 0, 32'h0,        0, 0, 0);
        add(0, 8'h00, 0, 8'hAB, 1, 1,  1, 1, 1,  1, 0, 32'h0,        0, 0, 0);
        add(0, 8'h00, 0, 8'hCD, 1, 1,  1, 0, 1,  1, 0, 32'h0,        0, 1, 0);
        add(0, 8'h00, 0, 8'hBE, 1, 1,  1, 0, 1,  1, 0, 32'h0,        0, 1, 0);
        add(0, 8'h00, 0, 8'hEF, 1, 1,  1, 0, 1,  1, 0, 32'h0,        0, 1, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0,  1, 1, 1,  1, 1, 32'hABCDBEEF, 1, 0, 0);
        add(1, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0,  1, 1, 32'hABCDBEEF, 1, 0, 0); // 55 reset while full
        add(0, 8'h00, 0, 8'h00, 0, 1,  1, 1, 1,  1, 0, 32'h0,        0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; d0 = tbl[i].d0; v0 = tbl[i].v0;
            d1 = tbl[i].d1; v1 = tbl[i].v1; wr = tbl[i].wr;
            #1;
            if (tbl[i].cr) begin
                chk("ch0_ready", i, 32'(r0), 32'(tbl[i].r0));
                chk("ch1_ready", i, 32'(r1), 32'(tbl[i].r1));
            end
            if (tbl[i].cg) begin
                chk("word_valid", i, 32'(wv), 32'(tbl[i].wv));
                chk("word_out", i, wo, tbl[i].wo);
                chk("word_src", i, 32'(ws), 32'(tbl[i].ws));
                chk("busy", i, 32'(bz), 32'(tbl[i].bz));
`ifdef WORD_ASSEMBLY_ERR_CNT_EN
                chk("drop_cnt", i, 32'(dc), 32'(tbl[i].dc));
`endif
            end
        end

        // Idle timeout measured in cycles, bounded wait on busy falling.
        begin
            int n;
            bit done;
            n = 0;
            done = 0;
            @(negedge clk);
            d0 = 8'hA9; v0 = 1'b1;
            @(negedge clk);
            v0 = 1'b0;
            #1;
            chk("busy_start", -1, 32'(bz), 32'd1);
            for (int k = 0; k < 20 && !done; k++) begin
                @(negedge clk);
                n++;
                if (!bz) done = 1;
            end
            chk("timeout_done", -1, 32'(done), 32'd1);
            chk("timeout_cycles", -1, 32'(n), 32'd4);
            chk("timeout_no_word", -1, 32'(wv), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
